// File: rtl/mod_mul_pkg.sv
// rtl/mod_mul_pkg.sv - shared constants and FSM state encoding for the modular multiplier
package mod_mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/mod_mul_step.sv
// rtl/mod_mul_step.sv - one interleaved iteration: acc = 2*acc + (bit ? a : 0), then up to two conditional subtracts of n
module mod_mul_step import mod_mul_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] modulus,
  input  logic             b_bit,
  output logic [WIDTH+1:0] acc_next
);

  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] sub1;
  logic [WIDTH+1:0] red1;
  logic [WIDTH+1:0] sub2;

  assign n_ext = {2'b00, modulus};
  assign sum   = (acc << 1) + (b_bit ? {2'b00, a} : '0);

  // Both differences are always formed and a mux picks the result, so the
  // logic exercised each cycle does not depend on operand values.
  assign sub1     = sum - n_ext;
  assign red1     = (sum >= n_ext) ? sub1 : sum;
  assign sub2     = red1 - n_ext;
  assign acc_next = (red1 >= n_ext) ? sub2 : red1;

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - constant-time (a*b) mod n, one multiplier bit per cycle, MSB first
// Optional operand range check enabled by defining MOD_MUL_OPERAND_CHECK_EN.
module mod_mul import mod_mul_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             finish,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic             accept;
  logic             last_iter;

  mod_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .a        (a_r),
    .modulus  (n_r),
    .b_bit    (b_r[LAST - cnt]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          last_iter  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      n_r     <= '0;
      product <= '0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        n_r <= modulus;
        acc <= '0;
        cnt <= '0;
      end else if (busy) begin
        acc <= acc_next;
        cnt <= last_iter ? '0 : cnt + 1'b1;
        if (last_iter) begin
          product <= acc_next[WIDTH-1:0];
          finish  <= 1'b1;
        end
      end
    end
  end

`ifdef MOD_MUL_OPERAND_CHECK_EN
  logic range_err;
  logic err_r;

  assign range_err = (a_r >= n_r) || (b_r >= n_r) || (n_r == '0);

  always_ff @(posedge clk) begin
    if (rst)            err_r <= 1'b0;
    else if (last_iter) err_r <= range_err;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - randomized self-checking bench for mod_mul (WIDTH=8)
module tb_mod_mul;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] modulus;
  logic [W-1:0] product;
  logic         busy;
  logic         finish;
  logic         err;

  int total = 0;
  int bad   = 0;

  mod_mul #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .modulus (modulus),
    .product (product),
    .busy    (busy),
    .finish  (finish),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: true modular product when operands are legal; otherwise the
  // interleaved algorithm evaluated on plain integers truncated to W+2 bits.
  function automatic int ref_product(input int ra, input int rb, input int rn);
    int acc;
    int mask;
    if (rn != 0 && ra < rn && rb < rn) return (ra * rb) % rn;
    mask = (1 << (W + 2)) - 1;
    acc  = 0;
    for (int i = W - 1; i >= 0; i--) begin
      acc = (acc * 2 + (((rb >> i) & 1) != 0 ? ra : 0)) & mask;
      if (acc >= rn) acc = (acc - rn) & mask;
      if (acc >= rn) acc = (acc - rn) & mask;
    end
    return acc & ((1 << W) - 1);
  endfunction

  function automatic logic ref_err(input int ra, input int rb, input int rn);
`ifdef MOD_MUL_OPERAND_CHECK_EN
    return (rn == 0) || (ra >= rn) || (rb >= rn);
`else
    return 1'b0;
`endif
  endfunction

  // Called just after a falling edge; returns at the falling edge where finish
  // is seen (lat = cycles after the start cycle) or lat = -1 on timeout.
  task automatic do_op(input int ia, input int ib, input int in,
                       output logic [W-1:0] p, output logic e, output int lat);
    start   = 1'b1;
    a       = W'(ia);
    b       = W'(ib);
    modulus = W'(in);
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    a       = W'($urandom);
    b       = W'($urandom);
    modulus = W'($urandom);
    lat = -1;
    p   = '0;
    e   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (finish) begin
        lat = k;
        p   = product;
        e   = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a = 8'd7; b = 8'd9; modulus = 8'd13;
    repeat (3) @(negedge clk);
    total++; if (product !== 8'd0) begin bad++; $display("FAIL reset_product: got %0d want 0", product); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (finish !== 1'b0)  begin bad++; $display("FAIL reset_finish: got %b want 0", finish); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int vec [4][3] = '{'{7, 9, 13}, '{200, 150, 251}, '{254, 254, 255}, '{0, 12, 13}};
    int want [4]   = '{11, 131, 1, 0};
    logic [W-1:0] p;
    logic e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(vec[i][0], vec[i][1], vec[i][2], p, e, lat);
      total++; if (lat != LAT) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT); end
      total++; if (p !== W'(want[i])) begin bad++; $display("FAIL vec%0d_product: got %0d want %0d", i, p, want[i]); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL vec%0d_err: got %b want 0", i, e); end
      @(negedge clk);
      total++; if (finish !== 1'b0) begin bad++; $display("FAIL vec%0d_pulse: finish still %b", i, finish); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] p;
    logic e;
    int lat, ra, rb, rn;
    for (int i = 0; i < 24; i++) begin
      rn = $urandom_range(255, 1);
      ra = $urandom_range(rn - 1, 0);
      rb = $urandom_range(rn - 1, 0);
      do_op(ra, rb, rn, p, e, lat);
      total++;
      if (lat != LAT || p !== W'(ref_product(ra, rb, rn))) begin
        bad++;
        $display("FAIL rand%0d: %0d*%0d mod %0d got %0d lat %0d want %0d lat %0d",
                 i, ra, rb, rn, p, lat, ref_product(ra, rb, rn), LAT);
      end
      if (i % 3 == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] p;
    logic e;
    int lat;
    int seen;
    start = 1'b1; a = 8'd200; b = 8'd150; modulus = 8'd251;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (product !== 0 || busy !== 0 || finish !== 0 || err !== 0) begin
      bad++;
      $display("FAIL mid_reset_outputs: product=%0d busy=%b finish=%b err=%b want all 0",
               product, busy, finish, err);
    end
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (finish) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_reset_no_finish: got %0d finishes want 0", seen); end
    do_op(7, 9, 13, p, e, lat);
    total++;
    if (lat != LAT || p !== 8'd11) begin
      bad++;
      $display("FAIL mid_reset_recover: got %0d lat %0d want 11 lat %0d", p, lat, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    int seen, lat;
    logic [W-1:0] p;
    start = 1'b1; a = 8'd7; b = 8'd9; modulus = 8'd13;
    @(posedge clk);
    seen = 0; lat = -1; p = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); modulus = W'($urandom_range(255, 1));
      if (k == 1) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", busy); end
      end
      if (finish) begin
        seen++;
        if (seen == 1) begin lat = k; p = product; end
        start = 1'b0;
      end
    end
    total++; if (seen != 1) begin bad++; $display("FAIL hold_single_finish: got %0d want 1", seen); end
    total++;
    if (lat != LAT || p !== 8'd11) begin
      bad++;
      $display("FAIL hold_result: got %0d lat %0d want 11 lat %0d", p, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p;
    logic e;
    int lat, ra, rb, rn;
    do_op(7, 9, 13, p, e, lat);
    total++; if (p !== 8'd11) begin bad++; $display("FAIL b2b_first: got %0d want 11", p); end
    for (int i = 0; i < 4; i++) begin
      rn = $urandom_range(255, 2);
      ra = $urandom_range(rn - 1, 0);
      rb = $urandom_range(rn - 1, 0);
      do_op(ra, rb, rn, p, e, lat);
      total++;
      if (lat != LAT || p !== W'(ref_product(ra, rb, rn))) begin
        bad++;
        $display("FAIL b2b%0d: got %0d lat %0d want %0d lat %0d", i, p, lat, ref_product(ra, rb, rn), LAT);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [W-1:0] p;
    logic e;
    int lat, ra, rb, rn;
    do_op(13, 2, 13, p, e, lat);
    total++;
    if (lat != LAT || p !== W'(ref_product(13, 2, 13)) || e !== ref_err(13, 2, 13)) begin
      bad++;
      $display("FAIL err_13_2_13: got p=%0d e=%b lat %0d want p=%0d e=%b lat %0d",
               p, e, lat, ref_product(13, 2, 13), ref_err(13, 2, 13), LAT);
    end
    repeat (3) @(negedge clk);
    total++; if (err !== ref_err(13, 2, 13)) begin bad++; $display("FAIL err_stable: got %b want %b", err, ref_err(13, 2, 13)); end
    for (int i = 0; i < 6; i++) begin
      rn = (i == 0) ? 0 : $urandom_range(200, 1);
      ra = $urandom_range(255, 0);
      rb = $urandom_range(255, rn);
      do_op(ra, rb, rn, p, e, lat);
      total++;
      if (lat != LAT || p !== W'(ref_product(ra, rb, rn)) || e !== ref_err(ra, rb, rn)) begin
        bad++;
        $display("FAIL err_rand%0d: a=%0d b=%0d n=%0d got p=%0d e=%b lat %0d want p=%0d e=%b",
                 i, ra, rb, rn, p, e, lat, ref_product(ra, rb, rn), ref_err(ra, rb, rn));
      end
    end
    do_op(7, 9, 13, p, e, lat);
    total++; if (e !== 1'b0 || p !== 8'd11) begin bad++; $display("FAIL err_clear: got p=%0d e=%b want 11 0", p, e); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; modulus = '0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_reset_mid();
    test_hold_start();
    test_back_to_back();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_mul.md
MOD_MUL -- requirements
Module: mod_mul

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/modulus/result bit width (>=2).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request, sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand, required a < modulus.
REQ-006 SHALL have port: b  input  WIDTH  multiplier, required b < modulus.
REQ-007 SHALL have port: modulus  input  WIDTH  modulus n, required n != 0.
REQ-008 SHALL have port: product  output  WIDTH  registered (a*b) mod n.
REQ-009 SHALL have port: busy  output  1  high while in CALC.
REQ-010 SHALL have port: finish  output  1  one-cycle pulse, product valid.
REQ-011 SHALL have port: err  output  1  operand-range error flag, valid with finish.

Function
REQ-012 SHALL implement states IDLE and CALC only; IDLE->CALC on start, CALC->IDLE after exactly WIDTH iterations.
REQ-013 SHALL capture a, b, modulus into internal registers on the IDLE edge where start=1; later input changes have no effect.
REQ-014 SHALL run one interleaved iteration per CALC cycle, b MSB first: acc = 2*acc + (b[i] ? a : 0), then subtract n if acc>=n, then subtract n again if acc>=n.
REQ-015 SHALL hold acc at WIDTH+2 bits internally; acc starts at 0 on start acceptance.
REQ-016 SHALL compute both subtraction candidates every iteration and select by mux, so timing and toggled logic depth are data-independent.
REQ-017 SHALL have constant latency: start sampled in cycle 0 -> finish high in cycle WIDTH+1 only, for any operand values.
REQ-018 SHALL update product on the same edge that raises finish; product held until the next result edge.
REQ-019 SHALL ignore start while busy=1 (no restart, no queueing).
REQ-020 SHALL allow start in the cycle finish is high; new operation accepted, same latency.
REQ-021 SHALL, on out-of-range operands (a>=n, b>=n or n==0), still run full WIDTH iterations; product = low WIDTH bits of final acc, err=1 with finish.
REQ-022 SHALL keep err stable from the finish edge until the next finish edge.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state=IDLE, counter=0, acc=0, captured operands=0, product=0, busy=0, finish=0, err=0.
REQ-024 SHALL abort any in-flight operation on reset; no finish pulse for it.
REQ-025 SHALL give reset priority over start in the same cycle.

Configuration
REQ-026 SHALL, with MOD_MUL_OPERAND_CHECK_EN defined, compute err per REQ-021 from captured operands.
REQ-027 SHALL, without MOD_MUL_OPERAND_CHECK_EN, tie err to 0 and remove range-compare logic; all other behaviour unchanged.

Structure
REQ-028 SHALL place state encodings (IDLE=0, CALC=1) and the default WIDTH constant in the shared secure-modules package.
REQ-029 SHALL isolate one iteration (double, conditional add, two conditional subtracts) in a combinational sub-module mod_mul_step, parameterised by WIDTH.
REQ-030 SHALL keep the FSM, iteration counter and registers in mod_mul top level.

Verification (WIDTH=8)
REQ-031 SHALL check a=7, b=9, n=13 -> product=11, err=0, finish exactly cycle 9 after start.
REQ-032 SHALL check a=200, b=150, n=251 -> product=131; a=254, b=254, n=255 -> product=1.
REQ-033 SHALL check a=0, b=0xFF-limited (b=12), n=13 -> product=0 with identical latency to REQ-031 (constant-time check).
REQ-034 SHALL check rst=1 asserted at cycle 4 of an operation -> no finish, all outputs 0, next start completes normally.
REQ-035 SHALL check start held high and operands changed during CALC -> single finish, result from originally captured operands; start in finish cycle -> back-to-back result 9 cycles later.
REQ-036 SHALL check a=13, b=2, n=13 with MOD_MUL_OPERAND_CHECK_EN -> err=1 at finish; without macro -> err=0.
